// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit lookahead slice per stage, valid/ready flow control.
// Build macro CLA_SAT_EN: on signed overflow the final stage saturates out_sum to the signed limit.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int SW = WIDTH / STAGES;

    // Lookahead slice: every carry is expanded from g/p and the slice carry-in, no intra-slice ripple.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic cin);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          cc;
        logic          pp;
        g    = a & b;
        p    = a ^ b;
        c    = {(SW+1){1'b0}};
        c[0] = cin;
        for (int i = 0; i < SW; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    logic             stall_s;
    logic             adv_s;
    logic             accept_s;
    logic [WIDTH-1:0] yp_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;

    assign stall_s   = out_valid_r & ~out_ready;
    assign adv_s     = ~stall_s;
    assign in_ready  = reset | ~stall_s;
    assign accept_s  = in_valid & ~stall_s;
    assign yp_s      = in_sub ? ~in_y : in_y;

    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;

    genvar k;
    generate
        for (k = 0; k < STAGES - 1; k++) begin : g_stage
            localparam int LO = (k + 1) * SW;
            localparam int HI = WIDTH - LO;

            logic          valid_r;
            logic [LO-1:0] sum_lo_r;
            logic [HI-1:0] x_hi_r;
            logic [HI-1:0] y_hi_r;
            logic          carry_r;
            logic          xmsb_r;
            logic          ymsb_r;

            logic [SW:0]   res_s;
            logic          nvalid_s;
            logic [LO-1:0] nsum_s;
            logic [HI-1:0] nx_s;
            logic [HI-1:0] ny_s;
            logic          nxm_s;
            logic          nym_s;

            if (k == 0) begin : g_src
                assign res_s    = cla_slice(in_x[SW-1:0], yp_s[SW-1:0], in_sub);
                assign nvalid_s = accept_s;
                assign nsum_s   = res_s[SW-1:0];
                assign nx_s     = in_x[WIDTH-1:SW];
                assign ny_s     = yp_s[WIDTH-1:SW];
                assign nxm_s    = in_x[WIDTH-1];
                assign nym_s    = yp_s[WIDTH-1];
            end else begin : g_src
                assign res_s    = cla_slice(g_stage[k-1].x_hi_r[SW-1:0], g_stage[k-1].y_hi_r[SW-1:0],
                                            g_stage[k-1].carry_r);
                assign nvalid_s = g_stage[k-1].valid_r;
                assign nsum_s   = {res_s[SW-1:0], g_stage[k-1].sum_lo_r};
                assign nx_s     = g_stage[k-1].x_hi_r[HI+SW-1:SW];
                assign ny_s     = g_stage[k-1].y_hi_r[HI+SW-1:SW];
                assign nxm_s    = g_stage[k-1].xmsb_r;
                assign nym_s    = g_stage[k-1].ymsb_r;
            end

            // Stage register: completed low bits, skewed high operand bits and the slice carry.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_r  <= 1'b0;
                    sum_lo_r <= {LO{1'b0}};
                    x_hi_r   <= {HI{1'b0}};
                    y_hi_r   <= {HI{1'b0}};
                    carry_r  <= 1'b0;
                    xmsb_r   <= 1'b0;
                    ymsb_r   <= 1'b0;
                end else if (adv_s) begin
                    valid_r  <= nvalid_s;
                    sum_lo_r <= nsum_s;
                    x_hi_r   <= nx_s;
                    y_hi_r   <= ny_s;
                    carry_r  <= res_s[SW];
                    xmsb_r   <= nxm_s;
                    ymsb_r   <= nym_s;
                end
            end
        end
    endgenerate

    logic [SW-1:0]    fa_s;
    logic [SW-1:0]    fb_s;
    logic             fcin_s;
    logic             fvalid_s;
    logic             fxm_s;
    logic             fym_s;
    logic [SW:0]      fres_s;
    logic [WIDTH-1:0] fsum_s;
    logic [WIDTH-1:0] fout_s;
    logic             fovf_s;

    generate
        if (STAGES == 1) begin : g_fin
            assign fa_s     = in_x;
            assign fb_s     = yp_s;
            assign fcin_s   = in_sub;
            assign fvalid_s = accept_s;
            assign fxm_s    = in_x[WIDTH-1];
            assign fym_s    = yp_s[WIDTH-1];
            assign fsum_s   = fres_s[SW-1:0];
        end else begin : g_fin
            assign fa_s     = g_stage[STAGES-2].x_hi_r;
            assign fb_s     = g_stage[STAGES-2].y_hi_r;
            assign fcin_s   = g_stage[STAGES-2].carry_r;
            assign fvalid_s = g_stage[STAGES-2].valid_r;
            assign fxm_s    = g_stage[STAGES-2].xmsb_r;
            assign fym_s    = g_stage[STAGES-2].ymsb_r;
            assign fsum_s   = {fres_s[SW-1:0], g_stage[STAGES-2].sum_lo_r};
        end
    endgenerate

    assign fres_s = cla_slice(fa_s, fb_s, fcin_s);

    // Final-stage overflow flag and result selection.
    always_comb begin
        fovf_s = (fxm_s == fym_s) && (fsum_s[WIDTH-1] != fxm_s);
`ifdef CLA_SAT_EN
        if (fovf_s) begin
            fout_s = {fxm_s, {(WIDTH-1){~fxm_s}}};
        end else begin
            fout_s = fsum_s;
        end
`else
        fout_s = fsum_s;
`endif
    end

    // Output register: sum, carry and overflow of one beat always move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= fvalid_s;
            out_sum_r   <= fout_s;
            out_cout_r  <= fres_s[SW];
            out_ovf_r   <= fovf_s;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed, table-driven bench for pipelined_cla_addsub at WIDTH=16, STAGES=2 (honours CLA_SAT_EN).
module tb_pipelined_cla_addsub;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int n_chk;
    int n_fail;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        sub;
        logic [15:0] sum;
        logic [15:0] sat;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vt [10];

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        logic [15:0] es;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = v.x;
        in_y      = v.y;
        in_sub    = v.sub;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        es = v.sum;
`ifdef CLA_SAT_EN
        if (v.ovf) es = v.sat;
`endif
        check({tag, "_latency"}, n, 2);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, v.cout);
        check({tag, "_ovf"}, out_ovf, v.ovf);
    endtask

    initial begin
        int          idx;
        int          got;
        int          hold;
        bit          first;
        bit          acc;
        bit          stale;
        logic [15:0] bp_exp [4];

        n_chk  = 0;
        n_fail = 0;
        //        x         y         sub   sum       sat       cout  ovf
        vt[0] = {16'h1234, 16'h0F0F, 1'b0, 16'h2143, 16'h2143, 1'b0, 1'b0};
        vt[1] = {16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        vt[2] = {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vt[3] = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        vt[4] = {16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vt[5] = {16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
        vt[6] = {16'h0007, 16'h0005, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
        vt[7] = {16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        vt[8] = {16'hABCD, 16'hABCD, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vt[9] = {16'h00FF, 16'hFF01, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        bp_exp[0] = 16'h0002;
        bp_exp[1] = 16'h0004;
        bp_exp[2] = 16'h0006;
        bp_exp[3] = 16'h0008;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        in_y      = 16'h0000;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready_after", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Backpressure: four beats back-to-back, three-cycle stall on the first result.
        idx   = 0;
        got   = 0;
        hold  = 0;
        first = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (idx < 4) begin
                in_valid = 1'b1;
                in_x     = 16'(idx + 1);
                in_y     = 16'(idx + 1);
                in_sub   = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && !first) begin
                first = 1'b1;
                hold  = 3;
            end
            out_ready = (hold == 0);
            #1;
            if (hold > 0) begin
                check("bp_in_ready_stall", in_ready, 0);
                check("bp_hold_sum", out_sum, 16'h0002);
                hold--;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_result%0d", got), out_sum, bp_exp[got]);
                got++;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        check("bp_count", got, 4);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_dup", out_valid, 0);

        // Reset with two beats in flight discards both.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'h0100;
        in_y     = 16'h0001;
        @(negedge clk);
        in_x     = 16'h0200;
        in_y     = 16'h0002;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) stale = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_stale", stale, 0);
        run_vec({16'h0010, 16'h0020, 1'b0, 16'h0030, 16'h0030, 1'b0, 1'b0}, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the single-cycle combinational 6-bit adder.
- Splits a WIDTH-bit operation into STAGES lookahead slices, one slice per cycle, with a registered carry between slices.
- Adds valid/ready flow control, subtraction, carry-out and signed-overflow flags.
- Sits on the PE psum path between the multiplier output and the psum scratchpad write port.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2, pipeline depth; slice width SW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_x  input  WIDTH  operand x (two's complement or unsigned).
- in_y  input  WIDTH  operand y.
- in_sub  input  1  0: x+y; 1: x−y.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of the MSB; for subtraction 1 = no borrow.
- out_ovf  output  1  signed overflow.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high.
- Arithmetic: effective y' = in_sub ? ~in_y : in_y; carry-in = in_sub. The result is x + y' + cin modulo 2^WIDTH.
- Carry-out: cout is the carry out of bit WIDTH-1.
- Overflow: ovf = (x[MSB] == y'[MSB]) && (sum[MSB] != x[MSB]).
- Slice k (0 = LSB) computes bits [k*SW +: SW] in pipeline stage k. Within a slice, carries use generate/propagate lookahead (g = x&y', p = x^y'); there is no ripple between slices in the same cycle.
- Each stage register holds:
  - valid bit;
  - completed low sum bits;
  - still-unprocessed high x/y' bits (skew);
  - the carry into the next slice;
  - the x[MSB]/y'[MSB] bits needed for ovf.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stall. STAGES=1 gives a registered single-cycle result.
- Throughput: one beat per cycle.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall, combinational.
  - During a stall every stage register holds its value; outputs stay stable and unchanged until the transfer.
  - On a non-stall cycle all stages advance. Bubbles (valid=0) advance like data; there is no bubble collapse.
  - Order is preserved. No beat is dropped or duplicated.
- An in_valid asserted while in_ready=0 is ignored. The source must hold it.
- Reset:
  - All valid bits, out_valid, out_sum, out_cout and out_ovf go to 0.
  - in_ready = 1 in the cycle after reset deasserts; it is also 1 during reset.
  - Reset mid-operation discards every in-flight beat.
- Simultaneous output transfer and input accept in the same cycle are legal when full. The pipeline shifts and stays full.
- Sum, cout and ovf of a beat always leave together, in the same cycle.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: when ovf=1, out_sum saturates to the signed limit. The limit is 0x7FF…F if x[MSB]=0, else 0x80…0. out_ovf is still reported as 1, and out_cout is unchanged. Saturation is applied in the final stage with no added latency.
- Undefined: out_sum wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
- Defaults (WIDTH=16, STAGES=2, SW=8) apply to every case.
- Add: x=0x1234, y=0x0F0F, sub=0 -> out_valid exactly 2 cycles later; sum=0x2143, cout=0, ovf=0.
- Cross-slice carry: 0x00FF+0x0001 -> sum=0x0100, cout=0. Then 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
- Overflow:
  - 0x7FFF+0x0001 -> ovf=1; sum=0x8000 (0x7FFF with CLA_SAT_EN).
  - Subtract 0x8000−0x0001 -> ovf=1; sum=0x7FFF (0x8000 with CLA_SAT_EN).
- Subtract with borrow: 0x0005−0x0007 -> sum=0xFFFE, cout=0, ovf=0. 0x0007−0x0005 -> sum=0x0002, cout=1.
- Backpressure:
  - Stimulus: stream 0x0001+0x0001, 0x0002+0x0002, 0x0003+0x0003, 0x0004+0x0004 back-to-back, with out_ready=0 for 3 cycles after the first out_valid.
  - Response: in_ready=0 during the stall; out_sum holds 0x0002; results 0x0002, 0x0004, 0x0006, 0x0008 arrive in order, none lost.
- Reset mid-flight: accept 2 beats, assert reset for 1 cycle -> out_valid stays 0 with no stale results. A new beat 0x0010+0x0020 then yields 0x0030 after 2 cycles.
